// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared types and constants for the masked, column-serial AES InvMixColumns.
// A masked byte is a codeword of (d+1) byte shares packed into cw_t; share s sits in
// bits [8s+7:8s]. All codeword-domain linear maps are bit matrices whose row i
// produces output bit i.
package inv_mix_columns_seq_pkg;

  // Masking order / codeword redundancy degree.
  localparam int unsigned d       = 1;
  localparam int unsigned NShares = d + 1;
  localparam int unsigned CwW     = 8 * NShares;
  localparam int unsigned RndW    = 8 * d;

  typedef logic [CwW-1:0]            cw_t;
  typedef cw_t [0:3]                 state_word_t;  // one column, row 0 first
  typedef state_word_t [0:3]         state_t;       // four columns, column 0 first
  typedef logic [RndW-1:0]           red_poly_t;    // randomness for one refresh
  typedef logic [CwW-1:0][CwW-1:0]   mm_matrix_t;   // codeword -> codeword
  typedef logic [RndW-1:0][RndW-1:0] bm_matrix_t;   // randomness -> randomness
  typedef logic [CwW-1:0][RndW-1:0]  mr_matrix_t;   // randomness -> zero codeword

  typedef enum logic [1:0] {StIdle, StBusy, StDone} fsm_e;

  // Inverse MDS matrix, InvMds[row][col].
  localparam logic [0:3][0:3][3:0] InvMds = '{
    '{4'd14, 4'd11, 4'd13, 4'd9},
    '{4'd9,  4'd14, 4'd11, 4'd13},
    '{4'd13, 4'd9,  4'd14, 4'd11},
    '{4'd11, 4'd13, 4'd9,  4'd14}
  };

  function automatic cw_t mul_mm(mm_matrix_t m, cw_t v);
    cw_t r;
    r = '0;
    for (int i = 0; i < CwW; i++) r[i] = ^(m[i] & v);
    return r;
  endfunction

  function automatic red_poly_t mul_bm(bm_matrix_t m, red_poly_t v);
    red_poly_t r;
    r = '0;
    for (int i = 0; i < RndW; i++) r[i] = ^(m[i] & v);
    return r;
  endfunction

  function automatic cw_t mul_mr(mr_matrix_t m, red_poly_t v);
    cw_t r;
    r = '0;
    for (int i = 0; i < CwW; i++) r[i] = ^(m[i] & v);
    return r;
  endfunction

endpackage

// File: rtl/inv_mix_column_single.sv
// Combinational masked InvMixColumns of one column.
//   col_i  : masked input column (four codewords)
//   rnd_i  : 16 fresh randomness words, one per partial product (index 4*row+col)
//   l_i    : codeword-domain doubling matrix (mul_L2)
//   b_i    : randomness mixing matrix applied before expansion
//   mc_i   : expansion of randomness into a codeword of zero (refresh)
//   col_o  : masked output column
module inv_mix_column_single
  import inv_mix_columns_seq_pkg::*;
(
  input  state_word_t      col_i,
  input  red_poly_t [0:15] rnd_i,
  input  mm_matrix_t       l_i,
  input  bm_matrix_t       b_i,
  input  mr_matrix_t       mc_i,
  output state_word_t      col_o
);

  // x2/x4/x8: chained doubling of each input codeword, shared across output rows.
  cw_t [0:3] x2, x4, x8;
  cw_t       prod;
  logic [3:0] k;

  always_comb begin
    x2 = '0;
    x4 = '0;
    x8 = '0;
    for (int j = 0; j < 4; j++) begin
      x2[j] = mul_mm(l_i, col_i[j]);
      x4[j] = mul_mm(l_i, x2[j]);
      x8[j] = mul_mm(l_i, x4[j]);
    end
  end

  always_comb begin
    col_o = '0;
    prod  = '0;
    k     = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        k    = InvMds[r][c];
        prod = '0;
        if (k[0]) prod = prod ^ col_i[c];
        if (k[1]) prod = prod ^ x2[c];
        if (k[2]) prod = prod ^ x4[c];
        if (k[3]) prod = prod ^ x8[c];
        // Refresh each product with its own randomness before it meets the others.
        prod     = prod ^ mul_mr(mc_i, mul_bm(b_i, rnd_i[4*r+c]));
        col_o[r] = col_o[r] ^ prod;
      end
    end
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Masked AES InvMixColumns, one column per cycle through a single shared column unit.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : input handshake for state_in (accepted only in IDLE)
//   rnd_in/rnd_req  : 16 randomness words, consumed on every BUSY cycle
//   L/B_ext_MC/MC   : codeword-domain matrices, held stable while busy
//   out_valid/ready : output handshake for state_out (held in DONE)
module inv_mix_columns_seq
  import inv_mix_columns_seq_pkg::*;
#(
  parameter int unsigned d = inv_mix_columns_seq_pkg::d
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  state_t           state_in,
  input  red_poly_t [0:15] rnd_in,
  output logic             rnd_req,
  input  mm_matrix_t       L,
  input  bm_matrix_t       B_ext_MC,
  input  mr_matrix_t       MC,
  output logic             out_valid,
  input  logic             out_ready,
  output state_t           state_out
);

  // Port types come from the package, so the order cannot be overridden per instance.
  if (d != inv_mix_columns_seq_pkg::d) begin : g_d_check
    $error("inv_mix_columns_seq: d must equal the package value");
  end

  fsm_e        fsm_q, fsm_d;
  logic [1:0]  col_q, col_d;
  state_t      in_q, in_d;
  state_t      out_q, out_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        rnd_req_q, rnd_req_d;
  state_word_t col_res;

  inv_mix_column_single u_col (
    .col_i (in_q[col_q]),
    .rnd_i (rnd_in),
    .l_i   (L),
    .b_i   (B_ext_MC),
    .mc_i  (MC),
    .col_o (col_res)
  );

  always_comb begin
    fsm_d = fsm_q;
    col_d = col_q;
    in_d  = in_q;
    out_d = out_q;
    unique case (fsm_q)
      StIdle: begin
        if (in_valid) begin
          in_d  = state_in;
          col_d = 2'd0;
          fsm_d = StBusy;
        end
      end
      StBusy: begin
        out_d[col_q] = col_res;
        // Counter holds at 3 so no fifth column is ever processed.
        if (col_q == 2'd3) fsm_d = StDone;
        else               col_d = col_q + 2'd1;
      end
      StDone: begin
        if (out_ready) fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
    // Handshake outputs are registered versions of the next state.
    in_ready_d  = (fsm_d == StIdle);
    out_valid_d = (fsm_d == StDone);
    rnd_req_d   = (fsm_d == StBusy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= StIdle;
      col_q       <= 2'd0;
      in_q        <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      rnd_req_q   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      col_q       <= col_d;
      in_q        <= in_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      rnd_req_q   <= rnd_req_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign rnd_req   = rnd_req_q;
  assign state_out = out_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: masks plain AES states with XOR shares, decodes the
// masked results and compares against a byte-level GF(2^8) reference.
module tb_inv_mix_columns_seq;
  import inv_mix_columns_seq_pkg::*;

  localparam int SW = $bits(state_t);
  typedef logic [SW-1:0] wide_t;
  typedef logic [0:3][0:3][7:0] plain_t;  // [column][row]

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, rnd_req, out_valid, out_ready;
  state_t           state_in, state_out;
  red_poly_t [0:15] rnd_in;
  mm_matrix_t       L;
  bm_matrix_t       B_ext_MC;
  mr_matrix_t       MC;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .rnd_in    (rnd_in),
    .rnd_req   (rnd_req),
    .L         (L),
    .B_ext_MC  (B_ext_MC),
    .MC        (MC),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = xt(t);
    end
    return r;
  endfunction

  // Circulant matrix product; base is the first row.
  function automatic plain_t circ(plain_t p, logic [7:0] b0, logic [7:0] b1,
                                  logic [7:0] b2, logic [7:0] b3);
    logic [7:0] base [4];
    plain_t o;
    base[0] = b0; base[1] = b1; base[2] = b2; base[3] = b3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[c][r] = 8'h00;
        for (int j = 0; j < 4; j++) o[c][r] = o[c][r] ^ gmul(base[(j - r + 4) % 4], p[c][j]);
      end
    return o;
  endfunction

  function automatic plain_t inv_mix(plain_t p);
    return circ(p, 8'd14, 8'd11, 8'd13, 8'd9);
  endfunction

  function automatic plain_t fwd_mix(plain_t p);
    return circ(p, 8'd2, 8'd3, 8'd1, 8'd1);
  endfunction

  function automatic state_t encode(plain_t p);
    state_t s;
    logic [7:0] acc, sh;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = p[c][r];
        for (int k = 0; k < NShares - 1; k++) begin
          sh = 8'($urandom);
          s[c][r][8*k +: 8] = sh;
          acc = acc ^ sh;
        end
        s[c][r][8*(NShares-1) +: 8] = acc;
      end
    return s;
  endfunction

  function automatic plain_t decode(state_t s);
    plain_t p;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        p[c][r] = 8'h00;
        for (int k = 0; k < NShares; k++) p[c][r] = p[c][r] ^ s[c][r][8*k +: 8];
      end
    return p;
  endfunction

  function automatic plain_t rand_plain();
    plain_t p;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) p[c][r] = 8'($urandom);
    return p;
  endfunction

  task automatic chk(input string tag, input wide_t obs, input wide_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rnd(input bit zero);
    for (int i = 0; i < 16; i++) rnd_in[i] = zero ? '0 : red_poly_t'($urandom);
  endtask

  // Called at a negedge in IDLE; returns at the negedge where out_valid is seen.
  // lat counts cycles after acceptance; rpos has bit n set when rnd_req was high n cycles on.
  task automatic run_op(input state_t m_in, input bit zero_rnd, output state_t m_out,
                        output int lat, output int rpos);
    in_valid = 1'b1;
    state_in = m_in;
    drive_rnd(zero_rnd);
    @(negedge clk);
    in_valid = 1'b0;
    state_in = encode(rand_plain());
    lat  = 0;
    rpos = 0;
    for (int n = 1; n <= 20; n++) begin
      if (rnd_req) rpos = rpos | (1 << n);
      if (out_valid) begin
        lat = n;
        break;
      end
      drive_rnd(zero_rnd);
      @(negedge clk);
    end
    m_out = state_out;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  cw_t       e_cw, w_cw;
  red_poly_t e_rp;
  state_t    m_in, m_out, m_hold;
  plain_t    p, q;
  int        lat, rpos;

  initial begin
    // Doubling matrix: xtime applied to every share independently.
    for (int c = 0; c < CwW; c++) begin
      e_cw = cw_t'(1) << c;
      for (int k = 0; k < NShares; k++) w_cw[8*k +: 8] = xt(e_cw[8*k +: 8]);
      for (int r = 0; r < CwW; r++) L[r][c] = w_cw[r];
    end
    // Refresh expansion: d random bytes become shares whose XOR is zero.
    for (int c = 0; c < RndW; c++) begin
      e_rp = red_poly_t'(1) << c;
      w_cw = '0;
      for (int k = 0; k < NShares - 1; k++) begin
        w_cw[8*k +: 8] = e_rp[8*k +: 8];
        w_cw[8*(NShares-1) +: 8] = w_cw[8*(NShares-1) +: 8] ^ e_rp[8*k +: 8];
      end
      for (int r = 0; r < CwW; r++) MC[r][c] = w_cw[r];
    end
    for (int r = 0; r < RndW; r++) B_ext_MC[r] = red_poly_t'($urandom);

    // Reset with in_valid and out_ready also high: reset must win.
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    state_in  = encode(rand_plain());
    drive_rnd(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_prio_in_ready", wide_t'(in_ready), wide_t'(1'b1));
    chk("rst_prio_rnd_req", wide_t'(rnd_req), wide_t'(1'b0));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", wide_t'(in_ready), wide_t'(1'b1));
    chk("reset_out_valid", wide_t'(out_valid), wide_t'(1'b0));
    chk("reset_rnd_req", wide_t'(rnd_req), wide_t'(1'b0));
    chk("reset_state_out", wide_t'(state_out), wide_t'(0));

    // FIPS-197 column with random other columns.
    p = rand_plain();
    p[0][0] = 8'h8e; p[0][1] = 8'h4d; p[0][2] = 8'ha1; p[0][3] = 8'hbc;
    run_op(encode(p), 1'b0, m_out, lat, rpos);
    q = decode(m_out);
    chk("fips_latency", wide_t'(lat), wide_t'(5));
    chk("fips_rnd_req_cycles", wide_t'(rpos), wide_t'(32'b11110));
    chk("fips_col0", wide_t'(q[0]), wide_t'(32'hdb135345));
    chk("fips_state", wide_t'(q), wide_t'(inv_mix(p)));
    release_out();
    chk("fips_back_to_idle", wide_t'(in_ready), wide_t'(1'b1));

    // Fixed points with zero and random refresh randomness.
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) p[c][r] = (t < 2) ? 8'h01 : 8'hc6;
      run_op(encode(p), t[0], m_out, lat, rpos);
      chk("fixed_point", wide_t'(decode(m_out)), wide_t'(p));
      release_out();
    end

    // Backpressure: held result, new input ignored while DONE.
    p = rand_plain();
    run_op(encode(p), 1'b0, m_hold, lat, rpos);
    chk("bp_result", wide_t'(decode(m_hold)), wide_t'(inv_mix(p)));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      state_in = encode(rand_plain());
      drive_rnd(1'b0);
      @(negedge clk);
      chk("bp_stable", wide_t'(state_out), wide_t'(m_hold));
      chk("bp_in_ready", wide_t'(in_ready), wide_t'(1'b0));
      chk("bp_out_valid", wide_t'(out_valid), wide_t'(1'b1));
    end
    in_valid = 1'b0;
    release_out();
    chk("bp_idle_in_ready", wide_t'(in_ready), wide_t'(1'b1));
    chk("bp_idle_out_valid", wide_t'(out_valid), wide_t'(1'b0));
    p = rand_plain();
    run_op(encode(p), 1'b0, m_out, lat, rpos);
    chk("bp_next_result", wide_t'(decode(m_out)), wide_t'(inv_mix(p)));
    release_out();

    // Reset during BUSY, column 2.
    in_valid = 1'b1;
    state_in = encode(rand_plain());
    @(negedge clk);
    in_valid = 1'b0;
    drive_rnd(1'b0);
    @(negedge clk);
    drive_rnd(1'b0);
    @(negedge clk);
    chk("midop_busy", wide_t'(rnd_req), wide_t'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midop_in_ready", wide_t'(in_ready), wide_t'(1'b1));
    chk("midop_out_valid", wide_t'(out_valid), wide_t'(1'b0));
    chk("midop_rnd_req", wide_t'(rnd_req), wide_t'(1'b0));
    chk("midop_state_out", wide_t'(state_out), wide_t'(0));
    repeat (6) @(negedge clk);
    chk("midop_no_late_valid", wide_t'(out_valid), wide_t'(1'b0));
    p = rand_plain();
    run_op(encode(p), 1'b0, m_out, lat, rpos);
    chk("midop_next_latency", wide_t'(lat), wide_t'(5));
    chk("midop_next_result", wide_t'(decode(m_out)), wide_t'(inv_mix(p)));
    release_out();

    // Round trip: forward MixColumns in the model, inverse in the DUT.
    for (int it = 0; it < 1000; it++) begin
      p = rand_plain();
      m_in = encode(fwd_mix(p));
      run_op(m_in, 1'b0, m_out, lat, rpos);
      chk("roundtrip", wide_t'(decode(m_out)), wide_t'(p));
      if (it % 100 == 0) chk("roundtrip_rnd_req", wide_t'(rpos), wide_t'(32'b11110));
      release_out();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
